// File: rtl/lpif_x8_asym2_quarter_master_gearbox_if.sv
// ---------------------------------------------------------------------------
// lpif_x8_asym2_quarter_master_gearbox_if
//
// Bundles the LPIF-side and PHY-side signals of the master-end quarter-rate
// gearbox. The clock and reset are not part of the bundle.
//
// Signals:
//   tx_online           TX enable (online, delayed by auto-sync)
//   rx_online           RX enable
//   dstrm_beat          downstream LPIF beat, one per clock while tx_online
//   tx_downstream_data  packed PHY word, beat k at [BEAT_W*k +: BEAT_W]
//   tx_downstream_push  one-cycle strobe qualifying tx_downstream_data
//   tx_phase            slot index the next downstream beat lands in
//   rx_upstream_data    received packed PHY word
//   rx_upstream_push    one-cycle strobe qualifying rx_upstream_data
//   ustrm_beat          unpacked upstream LPIF beat
//   ustrm_beat_vld      high while ustrm_beat carries a beat
//   rx_overflow         sticky: a word arrived before the previous one drained
//
// Modports:
//   master  the gearbox itself (master end of the link)
//   slave   the surrounding adapter / concat logic driving the gearbox
// ---------------------------------------------------------------------------
interface lpif_x8_asym2_quarter_master_gearbox_if #(
    parameter int BEAT_W = 145,
    parameter int RATIO  = 4
);
    localparam int WORD_W = BEAT_W * RATIO;
    localparam int PH_W   = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic                tx_online;
    logic                rx_online;
    logic [BEAT_W-1:0]   dstrm_beat;
    logic [WORD_W-1:0]   tx_downstream_data;
    logic                tx_downstream_push;
    logic [PH_W-1:0]     tx_phase;
    logic [WORD_W-1:0]   rx_upstream_data;
    logic                rx_upstream_push;
    logic [BEAT_W-1:0]   ustrm_beat;
    logic                ustrm_beat_vld;
    logic                rx_overflow;

    modport master (
        input  tx_online, rx_online, dstrm_beat, rx_upstream_data, rx_upstream_push,
        output tx_downstream_data, tx_downstream_push, tx_phase,
               ustrm_beat, ustrm_beat_vld, rx_overflow
    );

    modport slave (
        output tx_online, rx_online, dstrm_beat, rx_upstream_data, rx_upstream_push,
        input  tx_downstream_data, tx_downstream_push, tx_phase,
               ustrm_beat, ustrm_beat_vld, rx_overflow
    );
endinterface

// File: rtl/lpif_x8_asym2_quarter_master_gearbox.sv
// ---------------------------------------------------------------------------
// lpif_x8_asym2_quarter_master_gearbox
//
// Master-end gearbox between the LPIF adapter (full rate, one 145-bit beat
// per clock) and the quarter-rate PHY concat block (one 580-bit word per
// four clocks).
//   TX: four consecutive beats are packed into one word, oldest beat in the
//       least-significant slot, and pushed for one cycle.
//   RX: each received word is replayed as four sequential beats, beat 0 in
//       the cycle after the push. A push arriving while beats are still
//       pending replaces the word and raises the sticky rx_overflow.
//
// Ports:
//   clk_wr  single clock for all logic
//   rst_wr  asynchronous, active-high reset
//   lnk     gearbox bundle (master modport), see the interface file
//
// Build option:
//   LPIF_GEARBOX_IDLE_SUPPRESS_EN - when defined, an all-idle word (every
//   beat with valid=0 and dvalid=0) is not pushed on TX, and is replayed
//   with ustrm_beat_vld=0 on RX.
// ---------------------------------------------------------------------------
module lpif_x8_asym2_quarter_master_gearbox #(
    parameter int BEAT_W = 145,
    parameter int RATIO  = 4
) (
    input  logic clk_wr,
    input  logic rst_wr,
    lpif_x8_asym2_quarter_master_gearbox_if.master lnk
);
    localparam int              WORD_W  = BEAT_W * RATIO;
    localparam int              PH_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(RATIO - 1);

`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
    localparam int DVALID_BIT = 136;
    localparam int VALID_BIT  = 138;

    // A word is idle when no beat carries valid or dvalid.
    function automatic logic word_is_idle(input logic [WORD_W-1:0] w);
        word_is_idle = 1'b1;
        for (int k = 0; k < RATIO; k++) begin
            if (w[k*BEAT_W + VALID_BIT] || w[k*BEAT_W + DVALID_BIT])
                word_is_idle = 1'b0;
        end
    endfunction
`endif

    // -----------------------------------------------------------------------
    // TX: slot capture (p0) -> packed word register (p1)
    // -----------------------------------------------------------------------
    logic [PH_W-1:0]   tx_phase_p0;
    logic [BEAT_W-1:0] slot_p0 [RATIO-1];
    logic [WORD_W-1:0] tx_word;
    logic [WORD_W-1:0] tx_data_p1;
    logic              tx_push_p1;

    // The last beat of a word goes straight into the packed word, so only
    // RATIO-1 slots are ever held.
    always_comb begin
        tx_word = '0;
        for (int k = 0; k < RATIO - 1; k++)
            tx_word[k*BEAT_W +: BEAT_W] = slot_p0[k];
        tx_word[(RATIO-1)*BEAT_W +: BEAT_W] = lnk.dstrm_beat;
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            tx_phase_p0 <= '0;
            for (int k = 0; k < RATIO - 1; k++)
                slot_p0[k] <= '0;
            tx_data_p1  <= '0;
            tx_push_p1  <= 1'b0;
        end else if (!lnk.tx_online) begin
            // Going offline drops any partial word. A push registered on the
            // previous edge has already been presented for its one cycle.
            tx_phase_p0 <= '0;
            for (int k = 0; k < RATIO - 1; k++)
                slot_p0[k] <= '0;
            tx_push_p1  <= 1'b0;
        end else begin
            tx_push_p1 <= 1'b0;
            if (tx_phase_p0 == LAST_PH) begin
                tx_phase_p0 <= '0;
                for (int k = 0; k < RATIO - 1; k++)
                    slot_p0[k] <= '0;
`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
                if (!word_is_idle(tx_word)) begin
                    tx_data_p1 <= tx_word;
                    tx_push_p1 <= 1'b1;
                end
`else
                tx_data_p1 <= tx_word;
                tx_push_p1 <= 1'b1;
`endif
            end else begin
                tx_phase_p0 <= tx_phase_p0 + PH_W'(1);
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (tx_phase_p0 == PH_W'(k))
                        slot_p0[k] <= lnk.dstrm_beat;
                end
            end
        end
    end

    assign lnk.tx_phase           = tx_phase_p0;
    assign lnk.tx_downstream_data = tx_data_p1;
    assign lnk.tx_downstream_push = tx_push_p1;

    // -----------------------------------------------------------------------
    // RX: holding register (p0) -> emitted beat register (p1)
    // -----------------------------------------------------------------------
    logic [WORD_W-1:0] rx_hold_p0;
    logic [PH_W-1:0]   rx_idx_p0;    // next beat of rx_hold_p0 to emit
    logic              rx_busy_p0;   // beats of rx_hold_p0 still pending
    logic [BEAT_W-1:0] rx_sel_beat;
    logic [BEAT_W-1:0] rx_beat_p1;
    logic              rx_vld_p1;
    logic              rx_ovf;
`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
    logic              rx_quiet_p0;  // held word is all idle: replay with vld low
`endif

    always_comb begin
        rx_sel_beat = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (rx_idx_p0 == PH_W'(k))
                rx_sel_beat = rx_hold_p0[k*BEAT_W +: BEAT_W];
        end
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            rx_hold_p0  <= '0;
            rx_idx_p0   <= '0;
            rx_busy_p0  <= 1'b0;
            rx_beat_p1  <= '0;
            rx_vld_p1   <= 1'b0;
            rx_ovf      <= 1'b0;
`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
            rx_quiet_p0 <= 1'b0;
`endif
        end else if (!lnk.rx_online) begin
            rx_hold_p0  <= '0;
            rx_idx_p0   <= '0;
            rx_busy_p0  <= 1'b0;
            rx_beat_p1  <= '0;
            rx_vld_p1   <= 1'b0;
            rx_ovf      <= 1'b0;
`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
            rx_quiet_p0 <= 1'b0;
`endif
        end else if (lnk.rx_upstream_push) begin
            // Beat 0 is taken straight from the incoming word so it appears
            // in the very next cycle; a push on the cycle beat RATIO-1 is
            // presented finds busy already low and is seamless.
            if (rx_busy_p0)
                rx_ovf <= 1'b1;
            rx_hold_p0 <= lnk.rx_upstream_data;
            rx_beat_p1 <= lnk.rx_upstream_data[BEAT_W-1:0];
            rx_idx_p0  <= PH_W'(1);
            rx_busy_p0 <= (RATIO > 1);
`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
            rx_quiet_p0 <= word_is_idle(lnk.rx_upstream_data);
            rx_vld_p1   <= !word_is_idle(lnk.rx_upstream_data);
`else
            rx_vld_p1  <= 1'b1;
`endif
        end else if (rx_busy_p0) begin
            rx_beat_p1 <= rx_sel_beat;
            rx_idx_p0  <= rx_idx_p0 + PH_W'(1);
            rx_busy_p0 <= (rx_idx_p0 != LAST_PH);
`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
            rx_vld_p1  <= !rx_quiet_p0;
`else
            rx_vld_p1  <= 1'b1;
`endif
        end else begin
            rx_beat_p1 <= '0;
            rx_vld_p1  <= 1'b0;
        end
    end

    assign lnk.ustrm_beat     = rx_beat_p1;
    assign lnk.ustrm_beat_vld = rx_vld_p1;
    assign lnk.rx_overflow    = rx_ovf;

endmodule

// File: tb/tb_lpif_x8_asym2_quarter_master_gearbox.sv
module tb_lpif_x8_asym2_quarter_master_gearbox;
    logic clk_wr;
    logic rst_wr;
    int   n_tests = 0;
    int   n_fail  = 0;

    lpif_x8_asym2_quarter_master_gearbox_if gb ();

    lpif_x8_asym2_quarter_master_gearbox dut (
        .clk_wr (clk_wr),
        .rst_wr (rst_wr),
        .lnk    (gb)
    );

    initial begin
        clk_wr = 1'b0;
        forever #5 clk_wr = ~clk_wr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [579:0] act, input logic [579:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Beat: state=b[3:0], protid=b[1:0], valid, crc_valid=1, dvalid, crc=~b, data=16 copies of b
    function automatic logic [144:0] mk_beat(input logic [7:0] b, input logic v, input logic dv);
        mk_beat = {b[3:0], b[1:0], v, 1'b1, dv, ~b, {16{b}}};
    endfunction

`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
    function automatic logic all_idle(input logic [579:0] w);
        logic [144:0] bt;
        all_idle = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bt = w[k*145 +: 145];
            if (bt[138] || bt[136]) all_idle = 1'b0;
        end
    endfunction
`endif

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    // Behavioural model: TX collects beats in a queue and emits the word when
    // four have been gathered; RX replays a queue of pending beats.
    initial begin : compare_proc
        logic [144:0] txq[$];
        logic [144:0] rxq[$];
        logic [579:0] m_data;
        logic         m_push;
        logic [1:0]   m_phase;
        logic [144:0] m_beat;
        logic         m_vld;
        logic         m_ovf;
        logic [579:0] w;
`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
        logic         m_quiet;
        m_quiet = 1'b0;
`endif
        m_data = '0; m_push = 1'b0; m_phase = '0;
        m_beat = '0; m_vld = 1'b0; m_ovf = 1'b0;
        forever begin
            @(posedge clk_wr);
            if (rst_wr) begin
                txq.delete(); rxq.delete();
                m_data = '0; m_push = 1'b0; m_phase = '0;
                m_beat = '0; m_vld = 1'b0; m_ovf = 1'b0;
            end else begin
                m_push = 1'b0;
                if (!gb.tx_online) begin
                    txq.delete();
                end else begin
                    txq.push_back(gb.dstrm_beat);
                    if (txq.size() == 4) begin
                        w = {txq[3], txq[2], txq[1], txq[0]};
`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
                        if (!all_idle(w)) begin
                            m_data = w;
                            m_push = 1'b1;
                        end
`else
                        m_data = w;
                        m_push = 1'b1;
`endif
                        txq.delete();
                    end
                end
                m_phase = 2'(txq.size());

                if (!gb.rx_online) begin
                    rxq.delete();
                    m_ovf = 1'b0;
                end else if (gb.rx_upstream_push) begin
                    if (rxq.size() != 0) m_ovf = 1'b1;
                    rxq.delete();
                    for (int k = 0; k < 4; k++)
                        rxq.push_back(gb.rx_upstream_data[k*145 +: 145]);
`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
                    m_quiet = all_idle(gb.rx_upstream_data);
`endif
                end
                if (rxq.size() != 0) begin
                    m_beat = rxq.pop_front();
`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
                    m_vld = !m_quiet;
`else
                    m_vld = 1'b1;
`endif
                end else begin
                    m_beat = '0;
                    m_vld  = 1'b0;
                end
            end
            @(negedge clk_wr);
            if (!rst_wr) begin
                chk("cmp_tx_push",  580'(gb.tx_downstream_push), 580'(m_push));
                chk("cmp_tx_phase", 580'(gb.tx_phase), 580'(m_phase));
                chk("cmp_tx_data",  gb.tx_downstream_data, m_data);
                chk("cmp_rx_beat",  580'(gb.ustrm_beat), 580'(m_beat));
                chk("cmp_rx_vld",   580'(gb.ustrm_beat_vld), 580'(m_vld));
                chk("cmp_rx_ovf",   580'(gb.rx_overflow), 580'(m_ovf));
            end
        end
    end

    initial begin : stim
        logic [144:0] b [4];
        logic [144:0] c [4];
        logic [144:0] ab [4];
        logic [144:0] bb [4];
        logic [579:0] wa;
        logic [579:0] wb;
        logic [579:0] held;

        rst_wr = 1'b1;
        gb.tx_online = 1'b0;
        gb.rx_online = 1'b0;
        gb.dstrm_beat = '0;
        gb.rx_upstream_data = '0;
        gb.rx_upstream_push = 1'b0;
        repeat (3) @(posedge clk_wr);
        #1;
        rst_wr = 1'b0;

        // reset state
        chk("rst_tx_push",  580'(gb.tx_downstream_push), 580'(0));
        chk("rst_tx_phase", 580'(gb.tx_phase), 580'(0));
        chk("rst_tx_data",  gb.tx_downstream_data, 580'(0));
        chk("rst_rx_vld",   580'(gb.ustrm_beat_vld), 580'(0));
        chk("rst_rx_beat",  580'(gb.ustrm_beat), 580'(0));
        chk("rst_rx_ovf",   580'(gb.rx_overflow), 580'(0));
        tick();

        // TX pack
        b[0] = mk_beat(8'h11, 1'b1, 1'b1);
        b[1] = mk_beat(8'h22, 1'b1, 1'b1);
        b[2] = mk_beat(8'h33, 1'b1, 1'b0);
        b[3] = mk_beat(8'h44, 1'b0, 1'b1);
        gb.tx_online = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gb.dstrm_beat = b[i];
            chk("tx_phase_seq", 580'(gb.tx_phase), 580'(i));
            chk("tx_push_early", 580'(gb.tx_downstream_push), 580'(0));
            tick();
        end
        chk("tx_push", 580'(gb.tx_downstream_push), 580'(1));
        chk("tx_phase_wrap", 580'(gb.tx_phase), 580'(0));
        chk("tx_slot0", 580'(gb.tx_downstream_data[144:0]), 580'(b[0]));
        chk("tx_slot3", 580'(gb.tx_downstream_data[579:435]), 580'(b[3]));
        gb.tx_online = 1'b0;
        gb.dstrm_beat = '0;
        tick();
        chk("tx_push_once", 580'(gb.tx_downstream_push), 580'(0));
        chk("tx_data_hold", gb.tx_downstream_data, {b[3], b[2], b[1], b[0]});

        // TX abort after two beats, then a clean word
        gb.tx_online = 1'b1;
        gb.dstrm_beat = mk_beat(8'h55, 1'b1, 1'b1);
        tick();
        gb.dstrm_beat = mk_beat(8'h66, 1'b1, 1'b1);
        tick();
        gb.tx_online = 1'b0;
        tick();
        chk("tx_abort_phase", 580'(gb.tx_phase), 580'(0));
        chk("tx_abort_push", 580'(gb.tx_downstream_push), 580'(0));
        c[0] = mk_beat(8'h77, 1'b1, 1'b1);
        c[1] = mk_beat(8'h88, 1'b1, 1'b1);
        c[2] = mk_beat(8'h99, 1'b1, 1'b1);
        c[3] = mk_beat(8'hAA, 1'b1, 1'b1);
        gb.tx_online = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gb.dstrm_beat = c[i];
            chk("tx_restart_nopush", 580'(gb.tx_downstream_push), 580'(0));
            tick();
        end
        chk("tx_restart_push", 580'(gb.tx_downstream_push), 580'(1));
        chk("tx_restart_data", gb.tx_downstream_data, {c[3], c[2], c[1], c[0]});
        gb.tx_online = 1'b0;
        gb.dstrm_beat = '0;
        tick();

        // RX seamless back-to-back
        for (int k = 0; k < 4; k++) begin
            ab[k] = mk_beat(8'hA0 + 8'(k), 1'b1, 1'b1);
            bb[k] = mk_beat(8'hB0 + 8'(k), 1'b1, 1'b0);
        end
        wa = {ab[3], ab[2], ab[1], ab[0]};
        wb = {bb[3], bb[2], bb[1], bb[0]};
        gb.rx_online = 1'b1;
        gb.rx_upstream_data = wa;
        gb.rx_upstream_push = 1'b1;
        tick();
        gb.rx_upstream_push = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rx_seam_a", 580'(gb.ustrm_beat), 580'(ab[k]));
            chk("rx_seam_a_vld", 580'(gb.ustrm_beat_vld), 580'(1));
            if (k == 3) begin
                gb.rx_upstream_data = wb;
                gb.rx_upstream_push = 1'b1;
            end
            tick();
        end
        gb.rx_upstream_push = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rx_seam_b", 580'(gb.ustrm_beat), 580'(bb[k]));
            chk("rx_seam_b_vld", 580'(gb.ustrm_beat_vld), 580'(1));
            chk("rx_seam_ovf", 580'(gb.rx_overflow), 580'(0));
            tick();
        end
        chk("rx_seam_end_vld", 580'(gb.ustrm_beat_vld), 580'(0));
        chk("rx_seam_end_beat", 580'(gb.ustrm_beat), 580'(0));

        // RX overflow: second push two cycles after the first
        gb.rx_upstream_data = wa;
        gb.rx_upstream_push = 1'b1;
        tick();
        gb.rx_upstream_push = 1'b0;
        chk("rx_ovf_a0", 580'(gb.ustrm_beat), 580'(ab[0]));
        tick();
        chk("rx_ovf_a1", 580'(gb.ustrm_beat), 580'(ab[1]));
        gb.rx_upstream_data = wb;
        gb.rx_upstream_push = 1'b1;
        tick();
        gb.rx_upstream_push = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rx_ovf_b", 580'(gb.ustrm_beat), 580'(bb[k]));
            chk("rx_ovf_flag", 580'(gb.rx_overflow), 580'(1));
            tick();
        end
        chk("rx_ovf_idle_vld", 580'(gb.ustrm_beat_vld), 580'(0));
        chk("rx_ovf_sticky", 580'(gb.rx_overflow), 580'(1));
        gb.rx_online = 1'b0;
        tick();
        chk("rx_ovf_clear", 580'(gb.rx_overflow), 580'(0));

        // RX offline aborts emission and ignores pushes
        gb.rx_online = 1'b1;
        gb.rx_upstream_data = wa;
        gb.rx_upstream_push = 1'b1;
        tick();
        gb.rx_upstream_push = 1'b0;
        chk("rx_off_a0", 580'(gb.ustrm_beat), 580'(ab[0]));
        gb.rx_online = 1'b0;
        tick();
        chk("rx_off_vld", 580'(gb.ustrm_beat_vld), 580'(0));
        chk("rx_off_beat", 580'(gb.ustrm_beat), 580'(0));
        gb.rx_upstream_push = 1'b1;
        tick();
        gb.rx_upstream_push = 1'b0;
        chk("rx_off_ignore", 580'(gb.ustrm_beat_vld), 580'(0));
        tick();

        // Asynchronous reset in the middle of activity
        gb.tx_online = 1'b1;
        gb.rx_online = 1'b1;
        gb.dstrm_beat = b[0];
        tick();
        gb.dstrm_beat = b[1];
        tick();
        gb.dstrm_beat = b[2];
        gb.rx_upstream_data = wa;
        gb.rx_upstream_push = 1'b1;
        tick();
        gb.dstrm_beat = b[3];
        gb.rx_upstream_data = wb;
        tick();
        gb.rx_upstream_push = 1'b0;
        chk("pre_rst_push", 580'(gb.tx_downstream_push), 580'(1));
        chk("pre_rst_vld",  580'(gb.ustrm_beat_vld), 580'(1));
        chk("pre_rst_ovf",  580'(gb.rx_overflow), 580'(1));
        #2;
        rst_wr = 1'b1;
        #1;
        chk("arst_push",  580'(gb.tx_downstream_push), 580'(0));
        chk("arst_vld",   580'(gb.ustrm_beat_vld), 580'(0));
        chk("arst_ovf",   580'(gb.rx_overflow), 580'(0));
        chk("arst_phase", 580'(gb.tx_phase), 580'(0));
        chk("arst_data",  gb.tx_downstream_data, 580'(0));
        @(posedge clk_wr);
        #1;
        gb.tx_online = 1'b0;
        gb.rx_online = 1'b0;
        gb.dstrm_beat = '0;
        gb.rx_upstream_data = '0;
        rst_wr = 1'b0;
        tick();
        chk("post_rst_push", 580'(gb.tx_downstream_push), 580'(0));
        chk("post_rst_vld",  580'(gb.ustrm_beat_vld), 580'(0));

`ifdef LPIF_GEARBOX_IDLE_SUPPRESS_EN
        // Idle word is swallowed; a word with one valid beat is pushed
        held = gb.tx_downstream_data;
        gb.tx_online = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gb.dstrm_beat = mk_beat(8'hC0 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        chk("idle_nopush", 580'(gb.tx_downstream_push), 580'(0));
        chk("idle_hold", gb.tx_downstream_data, held);
        for (int i = 0; i < 4; i++) begin
            c[i] = mk_beat(8'hD0 + 8'(i), (i == 2), 1'b0);
            gb.dstrm_beat = c[i];
            tick();
        end
        chk("idle_push", 580'(gb.tx_downstream_push), 580'(1));
        chk("idle_push_data", gb.tx_downstream_data, {c[3], c[2], c[1], c[0]});
        gb.tx_online = 1'b0;
        gb.dstrm_beat = '0;
`else
        held = '0;
        chk("idle_feature_off_data", gb.tx_downstream_data, held);
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lpif_x8_asym2_quarter_master_gearbox.md
Name: lpif_x8_asym2_quarter_master_gearbox

Overview:
- Master-end counterpart of the x8 asym2 quarter-rate slave link.
- TX: packs four consecutive full-rate LPIF beats (145 bits each) into one 580-bit downstream word for the quarter-rate PHY concat logic.
- RX: unpacks each received 580-bit upstream word into four sequential LPIF beats.
- Sits between the master LPIF adapter and the master concat block, after auto-sync has delayed tx_online/rx_online.

Parameters:
- BEAT_W, 145: bits per LPIF beat. Layout: [127:0] data, [135:128] crc, [136] dvalid, [137] crc_valid, [138] valid, [140:139] protid, [144:141] state.
- RATIO, 4: beats per PHY word. Phase counter width is clog2(RATIO).

Ports:
- clk_wr  in  1  Single clock for all logic.
- rst_wr  in  1  Asynchronous, active-high reset.
- tx_online  in  1  TX enable (delayed online from auto-sync).
- rx_online  in  1  RX enable.
- dstrm_beat  in  145  Downstream LPIF beat, sampled every clk_wr while tx_online.
- tx_downstream_data  out  580  Packed word, beat k in [145k +: 145].
- tx_downstream_push  out  1  One-cycle strobe; tx_downstream_data is valid while it is high.
- tx_phase  out  2  Current TX slot index.
- rx_upstream_data  in  580  Received packed word.
- rx_upstream_push  in  1  One-cycle strobe qualifying rx_upstream_data.
- ustrm_beat  out  145  Unpacked upstream beat.
- ustrm_beat_vld  out  1  High while ustrm_beat carries a beat.
- rx_overflow  out  1  Sticky flag: a word arrived before the previous word was fully emitted.

Behaviour:
- Reset values: all outputs 0; phase counters 0; holding registers 0.
- TX packing:
  - tx_phase increments mod RATIO every cycle while tx_online=1.
  - Beat is captured into slot[tx_phase].
  - At tx_phase==3: the registered word {beat, slot2, slot1, slot0} is loaded into tx_downstream_data, and tx_downstream_push=1 for exactly the next cycle.
  - Latency: first beat sampled at edge t, push visible in cycle t+4 (after edge t+3).
  - With steady tx_online, push occurs every 4th cycle. tx_downstream_data holds its value between pushes.
- TX offline:
  - tx_online=0 forces tx_phase=0, clears the slots, and suppresses push.
  - tx_online falling mid-word discards the partial word; no push.
  - A push already registered on the falling edge still completes.
- RX unpacking:
  - rx_upstream_push=1 sampled at edge c (with rx_online=1) loads the holding register and the emit counter.
  - Beat k appears on ustrm_beat with ustrm_beat_vld=1 in cycle c+1+k, for k=0..3.
  - Outside an emission, ustrm_beat=0 and ustrm_beat_vld=0.
- RX back-to-back: a push at edge c+4 (same cycle beat 3 is presented) is seamless; beat 0 of the new word appears in cycle c+5 with no gap.
- RX overflow:
  - A push at edge c+1..c+3 sets rx_overflow.
  - The new word replaces the old one and emission restarts at beat 0 in the following cycle.
  - The remaining old beats are lost.
- RX offline:
  - rx_online=0 aborts any emission (ustrm_beat_vld=0 next cycle), clears the holding register and rx_overflow, and ignores pushes.
- Reset mid-operation: asynchronous; all state returns to reset values immediately. No push or beat is emitted until the next online-qualified activity.
- Beat fields pass through unmodified. No CRC checking is performed in this block.

Optional Feature:
- Macro LPIF_GEARBOX_IDLE_SUPPRESS_EN.
- When defined: at tx_phase==3, if all four beats have valid=0 and dvalid=0, tx_downstream_push is suppressed and tx_downstream_data is left unchanged. Slots are still cleared for the next word. On RX, a push whose four beats all have valid=0 and dvalid=0 still loads the holding register, but emits with ustrm_beat_vld=0.
- When undefined: every completed word is pushed and every received word is emitted with ustrm_beat_vld=1 for all four beats.

Test Plan:
- TX pack: tx_online=1, beats with data=0x11..,0x22..,0x33..,0x44.. on edges 0-3 -> push high in cycle 4 only; tx_downstream_data[144:0]=beat0 and [579:435]=beat3; tx_phase sequence 0,1,2,3,0.
- TX abort: tx_online drops after 2 beats -> no push, tx_phase=0 next cycle; restart with 4 beats -> single push with only the new beats.
- RX seamless: pushes at edges 10 and 14 with words A, B -> ustrm_beat = A0..A3 in cycles 11-14, then B0..B3 in cycles 15-18; ustrm_beat_vld continuously high; rx_overflow=0.
- RX overflow: pushes at edges 10 and 12 -> A0,A1 in cycles 11-12, B0..B3 in cycles 13-16; rx_overflow=1 and stays 1 until rx_online=0.
- Reset: assert rst_wr asynchronously mid-emission (between edges) -> ustrm_beat_vld, tx_downstream_push and rx_overflow go to 0 immediately, without waiting for a clock edge.
- Idle suppress (macro defined): four beats with valid=dvalid=0 -> no push; a following word with valid=1 on beat 2 -> push in the expected cycle.
